// File: rtl/fetch_ctrl_if.sv
// Board-side and fetch-side signals of the run-control sequencer.
// master: the sequencer itself. slave: the board / fetch stage around it.
// There is no valid/ready pair here. Event inputs are raw levels that
// the sequencer synchronises and debounces. Outputs are levels that the
// fetch stage samples on the falling clock edge.
interface fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ecall;
  logic             continue_button;
  logic             load_button;
  logic [2:0]       test_switch;
  logic             pc_load;
  logic             pc_write;
  logic [2:0]       test_number;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  ecall, continue_button, load_button, test_switch,
    output pc_load, pc_write, test_number, halted, state, instr_count
  );

  modport slave (
    output ecall, continue_button, load_button, test_switch,
    input  pc_load, pc_write, test_number, halted, state, instr_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Run-control sequencer for the instruction-fetch stage.
// Debounces the load/continue buttons and latches the test selection.
// Sequences PC load, advance and ecall halt/resume.
// Counts PC advances since the last load, saturating at all-ones.
module fetch_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input logic        clock,
  input logic        reset,
  fetch_ctrl_if.master bus
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_HALT   = 3'd3,
    S_RESUME = 3'd4
  } state_t;

  // Index 0 = continue button, index 1 = load button.
  logic [1:0]      btn_s1;
  logic [1:0]      btn_s2;
  logic [2:0]      sw_s1;
  logic [2:0]      sw_s2;
  logic [1:0]      db_level;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  state_t           st;
  logic [2:0]       tn;
  logic [CNT_W-1:0] cnt;
  logic             pc_write;
  logic             cont_ev;
  logic             load_ev;

  assign cont_ev = press[0];
  assign load_ev = press[1];

  // Two-flop synchronisers for both buttons and the switch bank.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= {bus.load_button, bus.continue_button};
      btn_s2 <= btn_s1;
      sw_s1  <= bus.test_switch;
      sw_s2  <= sw_s1;
    end
  end

  // Per-button debounce. The level flips after DB_CYCLES consecutive
  // differing samples. A release (1->0) emits a one-cycle press pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_level  <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (btn_s2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= btn_s2[i];
          db_cnt[i]   <= '0;
          press[i]    <= db_level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // RESUME always steps past the ecall, even though ecall is still high.
  assign pc_write = ((st == S_RUN) && !bus.ecall) || (st == S_RESUME);

  // Run-control FSM, test-number latch and saturating advance counter.
  // A load event overrides everything, including a coincident continue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st  <= S_IDLE;
      tn  <= '0;
      cnt <= '0;
    end else if (load_ev) begin
      st  <= S_LOAD;
      tn  <= sw_s2;
      cnt <= '0;
    end else begin
      case (st)
        S_IDLE:   st <= S_IDLE;
        S_LOAD:   st <= S_RUN;
        S_RUN:    if (bus.ecall) st <= S_HALT;
        S_HALT:   if (cont_ev) st <= S_RESUME;
        S_RESUME: st <= S_RUN;
        default:  st <= S_IDLE;
      endcase
      if (pc_write && (cnt != '1)) cnt <= cnt + 1'b1;
    end
  end

  assign bus.state       = st;
  assign bus.pc_load     = (st == S_LOAD);
  assign bus.halted      = (st == S_HALT);
  assign bus.pc_write    = pc_write;
  assign bus.test_number = tn;
  assign bus.instr_count = cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: scenario tasks plus a lock-step reference model.
module tb_fetch_ctrl;
  localparam int DB    = 4;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int LAT   = DB + 3;  // release -> LOAD state: 2 sync + DB samples + 1 FSM edge

  logic clock;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 0;

  fetch_ctrl_if #(.CNT_W(CW)) bus ();
  fetch_ctrl #(.DB_CYCLES(DB), .CNT_W(CW)) dut (.clock(clock), .reset(reset), .bus(bus));

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model ----------------
  // States by name: 0 idle, 1 load, 2 run, 3 halt, 4 resume.
  int   m_state = 0;
  int   m_tn    = 0;
  int   m_cnt   = 0;
  bit   m_s1 [2];
  bit   m_s2 [2];
  int   m_sw1 = 0;
  int   m_sw2 = 0;
  bit   m_lvl [2];
  bit   m_press [2];
  bit   hist_c [$];
  bit   hist_l [$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_state = 0; m_tn = 0; m_cnt = 0; m_sw1 = 0; m_sw2 = 0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_press[b] = 0;
      end
      hist_c.delete();
      hist_l.delete();
    end else begin
      bit pw;
      bit all_diff;
      int nst;
      pw  = ((m_state == 2) && !bus.ecall) || (m_state == 4);
      nst = m_state;
      if (m_press[1]) begin
        nst = 1; m_tn = m_sw2; m_cnt = 0;
      end else begin
        if (m_state == 1) nst = 2;
        else if (m_state == 2 && bus.ecall) nst = 3;
        else if (m_state == 3 && m_press[0]) nst = 4;
        else if (m_state == 4) nst = 2;
        if (pw && m_cnt < CMAX) m_cnt = m_cnt + 1;
      end
      m_state = nst;
      // A debounced level flips once the last DB synchronised samples all disagree with it.
      hist_c.push_back(m_s2[0]);
      if (hist_c.size() > DB) void'(hist_c.pop_front());
      all_diff = (hist_c.size() == DB);
      foreach (hist_c[k]) if (hist_c[k] == m_lvl[0]) all_diff = 0;
      m_press[0] = 0;
      if (all_diff) begin m_lvl[0] = !m_lvl[0]; m_press[0] = !m_lvl[0]; end
      hist_l.push_back(m_s2[1]);
      if (hist_l.size() > DB) void'(hist_l.pop_front());
      all_diff = (hist_l.size() == DB);
      foreach (hist_l[k]) if (hist_l[k] == m_lvl[1]) all_diff = 0;
      m_press[1] = 0;
      if (all_diff) begin m_lvl[1] = !m_lvl[1]; m_press[1] = !m_lvl[1]; end
      m_s2[0] = m_s1[0]; m_s2[1] = m_s1[1];
      m_s1[0] = bus.continue_button; m_s1[1] = bus.load_button;
      m_sw2 = m_sw1; m_sw1 = int'(bus.test_switch);
    end
  end

  // Lock-step scoreboard: every falling edge, DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      logic [2:0]    e_state;
      logic          e_pw;
      logic [CW-1:0] e_cnt;
      logic [2:0]    e_tn;
      e_state = m_state[2:0];
      e_pw    = ((m_state == 2) && !bus.ecall) || (m_state == 4);
      e_cnt   = m_cnt[CW-1:0];
      e_tn    = m_tn[2:0];
      n_cmp++;
      if (bus.state !== e_state || bus.pc_write !== e_pw || bus.instr_count !== e_cnt ||
          bus.test_number !== e_tn || bus.pc_load !== (m_state == 1) || bus.halted !== (m_state == 3)) begin
        n_bad++;
        $display("FAIL lockstep t=%0t: got state=%0d pcw=%0b cnt=%0d tn=%0d ld=%0b h=%0b, want state=%0d pcw=%0b cnt=%0d tn=%0d",
                 $time, bus.state, bus.pc_write, bus.instr_count, bus.test_number, bus.pc_load, bus.halted,
                 e_state, e_pw, e_cnt, e_tn);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Clean load press; returns edges from release until the LOAD state (0 on timeout).
  task automatic press_load(output int waited);
    waited = 0;
    bus.load_button = 1'b1;
    tick(6);
    bus.load_button = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (bus.state === 3'd1) begin waited = k; break; end
    end
  endtask

  task automatic press_continue();
    bus.continue_button = 1'b1;
    tick(6);
    bus.continue_button = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_cmp++;
    if (bus.state !== 3'd0 || bus.pc_load !== 1'b0 || bus.pc_write !== 1'b0 ||
        bus.halted !== 1'b0 || bus.instr_count !== '0 || bus.test_number !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_values: state=%0d ld=%0b pcw=%0b h=%0b cnt=%0d tn=%0d, want all 0",
               bus.state, bus.pc_load, bus.pc_write, bus.halted, bus.instr_count, bus.test_number);
    end
    reset = 1'b0;
    chk_en = 1'b1;
    tick(3);
  endtask

  task automatic test_load();
    int w;
    bus.test_switch = 3'd3;
    press_load(w);
    n_cmp++;
    if (w != LAT) begin n_bad++; $display("FAIL load_latency: got %0d want %0d", w, LAT); end
    n_cmp++;
    if (bus.pc_load !== 1'b1 || bus.test_number !== 3'd3 || bus.instr_count !== '0) begin
      n_bad++;
      $display("FAIL load_state: ld=%0b tn=%0d cnt=%0d, want 1 3 0", bus.pc_load, bus.test_number, bus.instr_count);
    end
    tick(1);
    n_cmp++;
    if (bus.state !== 3'd2 || bus.pc_load !== 1'b0) begin
      n_bad++; $display("FAIL load_to_run: state=%0d ld=%0b, want 2 0", bus.state, bus.pc_load);
    end
  endtask

  task automatic test_run_ecall();
    tick(10);
    n_cmp++;
    if (bus.instr_count !== 16'd10 || bus.pc_write !== 1'b1) begin
      n_bad++; $display("FAIL run_count: cnt=%0d pcw=%0b, want 10 1", bus.instr_count, bus.pc_write);
    end
    bus.ecall = 1'b1;
    #1;
    n_cmp++;
    if (bus.pc_write !== 1'b0 || bus.state !== 3'd2) begin
      n_bad++; $display("FAIL ecall_comb: pcw=%0b state=%0d, want 0 2", bus.pc_write, bus.state);
    end
    tick(1);
    n_cmp++;
    if (bus.state !== 3'd3 || bus.halted !== 1'b1 || bus.instr_count !== 16'd10) begin
      n_bad++; $display("FAIL ecall_halt: state=%0d h=%0b cnt=%0d, want 3 1 10", bus.state, bus.halted, bus.instr_count);
    end
  endtask

  task automatic test_glitch_resume();
    logic [CW-1:0] saved;
    int w;
    for (int g = 0; g < 6; g++) begin
      bus.continue_button = 1'b1;
      tick($urandom_range(1, 2));
      bus.continue_button = 1'b0;
      tick($urandom_range(2, 3));
    end
    tick(8);
    n_cmp++;
    if (bus.state !== 3'd3) begin n_bad++; $display("FAIL glitch_ignored: state=%0d want 3", bus.state); end
    saved = bus.instr_count;
    press_continue();
    w = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (bus.state === 3'd4) begin w = k; break; end
    end
    n_cmp++;
    if (w != LAT || bus.pc_write !== 1'b1) begin
      n_bad++; $display("FAIL resume: latency=%0d pcw=%0b, want %0d 1", w, bus.pc_write, LAT);
    end
    tick(1);
    n_cmp++;
    if (bus.state !== 3'd2 || bus.instr_count !== saved + 1'b1) begin
      n_bad++; $display("FAIL resume_step: state=%0d cnt=%0d, want 2 %0d", bus.state, bus.instr_count, saved + 1'b1);
    end
    tick(1);
    n_cmp++;
    if (bus.state !== 3'd3) begin n_bad++; $display("FAIL rehalt: state=%0d want 3", bus.state); end
  endtask

  task automatic test_coincide();
    logic [2:0] sw;
    int w;
    sw = 3'($urandom_range(4, 7));
    bus.test_switch = sw;
    bus.load_button = 1'b1;
    bus.continue_button = 1'b1;
    tick(6);
    bus.load_button = 1'b0;
    bus.continue_button = 1'b0;
    w = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (bus.state !== 3'd3) begin w = k; break; end
    end
    n_cmp++;
    if (w != LAT || bus.state !== 3'd1 || bus.instr_count !== '0 || bus.test_number !== sw) begin
      n_bad++;
      $display("FAIL coincide: after %0d state=%0d cnt=%0d tn=%0d, want %0d 1 0 %0d",
               w, bus.state, bus.instr_count, bus.test_number, LAT, sw);
    end
    bus.test_switch = ~sw;
    tick(2);
    n_cmp++;
    if (bus.test_number !== sw) begin n_bad++; $display("FAIL tn_hold: got %0d want %0d", bus.test_number, sw); end
  endtask

  task automatic test_reset_mid();
    int w;
    press_load(w);
    bus.ecall = 1'b0;
    tick(6);
    n_cmp++;
    if (bus.state !== 3'd2 || bus.instr_count !== 16'd5) begin
      n_bad++; $display("FAIL pre_reset: state=%0d cnt=%0d, want 2 5", bus.state, bus.instr_count);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.state !== 3'd0 || bus.pc_write !== 1'b0 || bus.pc_load !== 1'b0 ||
        bus.halted !== 1'b0 || bus.instr_count !== '0 || bus.test_number !== 3'd0) begin
      n_bad++; $display("FAIL async_reset: state=%0d pcw=%0b cnt=%0d tn=%0d, want all 0",
                        bus.state, bus.pc_write, bus.instr_count, bus.test_number);
    end
    tick(2);
    reset = 1'b0;
    press_continue();
    for (int k = 0; k < 15; k++) begin
      tick(1);
      n_cmp++;
      if (bus.state !== 3'd0 || bus.pc_write !== 1'b0) begin
        n_bad++; $display("FAIL idle_continue: cycle %0d state=%0d pcw=%0b, want 0 0", k, bus.state, bus.pc_write);
      end
    end
  endtask

  task automatic test_random();
    int hold_c = 0;
    int hold_l = 0;
    for (int k = 0; k < 600; k++) begin
      if (hold_c == 0) begin bus.continue_button = 1'($urandom_range(0, 1)); hold_c = $urandom_range(1, 9); end
      if (hold_l == 0) begin bus.load_button = 1'($urandom_range(0, 3) == 0); hold_l = $urandom_range(1, 12); end
      hold_c--; hold_l--;
      bus.ecall = 1'($urandom_range(0, 3) == 0);
      bus.test_switch = 3'($urandom_range(0, 7));
      tick(1);
    end
    bus.continue_button = 1'b0;
    bus.load_button = 1'b0;
    tick(15);
  endtask

  task automatic test_saturate();
    int w;
    press_load(w);
    n_cmp++;
    if (w == 0) begin n_bad++; $display("FAIL sat_load_timeout: state=%0d", bus.state); end
    bus.ecall = 1'b0;
    tick(1);
    tick(CMAX - 1);
    n_cmp++;
    if (bus.instr_count !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre: got %h want fffe", bus.instr_count); end
    tick(3);
    n_cmp++;
    if (bus.instr_count !== 16'hFFFF || bus.pc_write !== 1'b1) begin
      n_bad++; $display("FAIL saturate: cnt=%h pcw=%0b, want ffff 1", bus.instr_count, bus.pc_write);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    bus.ecall = 1'b0;
    bus.continue_button = 1'b0;
    bus.load_button = 1'b0;
    bus.test_switch = 3'd0;
    test_reset();
    test_load();
    test_run_ecall();
    test_glitch_resume();
    test_coincide();
    test_reset_mid();
    test_random();
    test_saturate();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
